// File: rtl/game_pkg.sv
// Shared encodings and BCD helpers for the game-flow controller.
// The score is three packed BCD digits: {hundreds, tens, ones}.
package game_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_DYING = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    localparam int BCD_W   = 4;
    localparam int SCORE_W = 12;

    function automatic logic bcd_gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        if (a[11:8] != b[11:8]) return a[11:8] > b[11:8];
        if (a[7:4] != b[7:4])   return a[7:4] > b[7:4];
        return a[3:0] > b[3:0];
    endfunction

    // Ripple ones->tens->hundreds; holds at 999 instead of wrapping.
    function automatic logic [SCORE_W-1:0] bcd_inc_sat(input logic [SCORE_W-1:0] a);
        logic [SCORE_W-1:0] r;
        r = a;
        if (a != 12'h999) begin
            if (a[3:0] != 4'd9) begin
                r[3:0] = a[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (a[7:4] != 4'd9) begin
                    r[7:4] = a[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = a[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, hold-time debounce, one-cycle press pulse on accepted 0->1.
// Latency raw->press is 2 + DEBOUNCE_CYC cycles; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // The count only runs while the synced level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync[1];
                    press <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: IDLE/PLAY/DYING/OVER FSM, BCD score with per-frame increment limit, best score.
// Press to state change is 1 cycle; outputs are registered; no backpressure.
module game_sequencer
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int DYING_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vneg,
    input  logic        dn,
    input  logic        btn,
    input  logic        collide,
    input  logic        pass,
    output logic        start,
    output logic        fail,
    output logic        up,
    output logic [1:0]  state,
    output logic [3:0]  ge,
    output logic [3:0]  shi,
    output logic [3:0]  bai,
    output logic [11:0] best,
    output logic        new_best
);

    localparam logic [7:0] DYING_LAST = 8'(DYING_FRAMES - 1);

    logic               flap_level, flap_press, restart_press;
    logic [2:0]         vsync;
    logic               frame_tick;
    logic [1:0]         st_q, st_nxt;
    logic               start_nxt, fail_nxt;
    logic [7:0]         dying_cnt;
    logic [SCORE_W-1:0] score;
    logic               pass_q, scored, inc;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_flap (
        .clk(clk), .rst(rst), .raw(~dn), .level(flap_level), .press(flap_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_restart (
        .clk(clk), .rst(rst), .raw(btn), .level(), .press(restart_press)
    );

    assign frame_tick = vsync[1] & ~vsync[2];
    assign inc = (st_q == ST_PLAY) & pass & ~pass_q & ~collide & ~scored;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q  <= ST_IDLE;
            start <= 1'b0;
            fail  <= 1'b0;
            up    <= 1'b0;
        end else begin
            st_q  <= st_nxt;
            start <= start_nxt;
            fail  <= fail_nxt;
            up    <= flap_level & (st_nxt == ST_PLAY);
        end
    end

    always_comb begin
        st_nxt = st_q;
        case (st_q)
            ST_IDLE:  if (flap_press) st_nxt = ST_PLAY;
            ST_PLAY:  if (collide) st_nxt = ST_DYING;
            ST_DYING: if (frame_tick && dying_cnt == DYING_LAST) st_nxt = ST_OVER;
            default:  if (restart_press) st_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start_nxt = (st_nxt == ST_PLAY);
        fail_nxt  = (st_nxt == ST_DYING) | (st_nxt == ST_OVER);
    end

    assign state = st_q;
    assign {bai, shi, ge} = score;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync     <= 3'b000;
            pass_q    <= 1'b0;
            scored    <= 1'b0;
            dying_cnt <= 8'd0;
            score     <= '0;
            best      <= '0;
            new_best  <= 1'b0;
        end else begin
            vsync  <= {vsync[1:0], vneg};
            pass_q <= pass;

            // One scoring pass edge per frame; the window reopens on the next frame tick.
            if (st_q != ST_PLAY) scored <= 1'b0;
            else if (inc)        scored <= 1'b1;
            else if (frame_tick) scored <= 1'b0;

            if (st_q != ST_DYING) dying_cnt <= 8'd0;
            else if (frame_tick)  dying_cnt <= dying_cnt + 8'd1;

            if (st_q == ST_OVER && st_nxt == ST_IDLE) score <= '0;
            else if (inc)                             score <= bcd_inc_sat(score);

            if (st_q == ST_DYING && st_nxt == ST_OVER) begin
                if (bcd_gt(score, best)) begin
                    best     <= score;
                    new_best <= 1'b1;
                end
            end else if (st_q == ST_OVER && st_nxt == ST_IDLE) begin
                new_best <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomised self-checking bench for game_sequencer with a game-level score/best model.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vneg = 1'b0, dn = 1'b1, btn = 1'b0, collide = 1'b0, pass = 1'b0;
    logic        start, fail, up, new_best;
    logic [1:0]  state;
    logic [3:0]  ge, shi, bai;
    logic [11:0] best;

    int n_tests = 0;
    int n_fail  = 0;
    int m_score = 0;
    int m_best  = 0;

    game_sequencer #(.DEBOUNCE_CYC(8), .DYING_FRAMES(3)) dut (
        .clk(clk), .rst(rst), .vneg(vneg), .dn(dn), .btn(btn), .collide(collide), .pass(pass),
        .start(start), .fail(fail), .up(up), .state(state), .ge(ge), .shi(shi), .bai(bai),
        .best(best), .new_best(new_best)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int n);
        return 12'((n / 100) * 256 + ((n / 10) % 10) * 16 + (n % 10));
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        vneg = 1'b1; cyc(6);
        vneg = 1'b0; cyc(6);
    endtask

    task automatic pass_pulse();
        pass = 1'b1; cyc($urandom_range(1, 3));
        pass = 1'b0; cyc($urandom_range(1, 3));
    endtask

    task automatic press_flap();
        dn = 1'b0; cyc(20);
        dn = 1'b1; cyc(20);
    endtask

    task automatic press_restart();
        btn = 1'b1; cyc(20);
        btn = 1'b0; cyc(20);
    endtask

    task automatic check_score(input string tag);
        check(tag, {20'd0, bai, shi, ge}, {20'd0, to_bcd(m_score)});
    endtask

    // n scoring passes, each in its own frame; dbl adds an extra edge in the first frame.
    task automatic do_passes(input int n, input bit dbl);
        for (int i = 0; i < n; i++) begin
            pass_pulse();
            if (dbl && i == 0) pass_pulse();
            frame();
            if (m_score < 999) m_score++;
            check_score("score_pass");
        end
    endtask

    task automatic end_game();
        bit exp_nb;
        collide = 1'b1; pass = 1'b1; cyc(1);
        collide = 1'b0; pass = 1'b0; cyc(1);
        check("dying_state", {30'd0, state}, 32'd2);
        check("dying_fail", {31'd0, fail}, 32'd1);
        check("dying_start", {31'd0, start}, 32'd0);
        check_score("collide_no_inc");
        frame(); frame();
        check("still_dying", {30'd0, state}, 32'd2);
        frame();
        check("over_state", {30'd0, state}, 32'd3);
        exp_nb = (m_score > m_best);
        if (exp_nb) m_best = m_score;
        check("best", {20'd0, best}, {20'd0, to_bcd(m_best)});
        check("new_best", {31'd0, new_best}, {31'd0, exp_nb});
        press_restart();
        m_score = 0;
        check("restart_idle", {30'd0, state}, 32'd0);
        check_score("restart_score");
        check("restart_nb", {31'd0, new_best}, 32'd0);
        check("restart_fail", {31'd0, fail}, 32'd0);
    endtask

    task automatic play_game(input int n, input bit dbl);
        press_flap();
        check("play_state", {30'd0, state}, 32'd1);
        check("play_start", {31'd0, start}, 32'd1);
        do_passes(n, dbl);
        end_game();
    endtask

    initial begin
        int n;
        cyc(3);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_outs", {28'd0, start, fail, up, new_best}, 32'd0);
        check("rst_best", {20'd0, best}, 32'd0);
        rst = 1'b1;
        cyc(2);

        dn = 1'b0; cyc(4); dn = 1'b1; cyc(20);
        check("bounce_idle", {30'd0, state}, 32'd0);
        press_restart();
        check("restart_in_idle", {30'd0, state}, 32'd0);

        play_game(5, 1'b1);
        play_game(3, 1'b0);
        for (int g = 0; g < 3; g++) play_game($urandom_range(0, 14), 1'($urandom_range(0, 1)));

        // Flap latency: 2 sync + 8 debounce + 1 FSM edges.
        dn = 1'b0;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (state == 2'b01) begin n = i; break; end
        end
        check("flap_latency", n, 11);
        check("latency_start", {31'd0, start}, 32'd1);
        cyc(1);
        check("up_held", {31'd0, up}, 32'd1);
        dn = 1'b1; cyc(20);
        check("up_released", {31'd0, up}, 32'd0);
        do_passes(11, 1'b0);
        check("ge_11", {28'd0, ge}, 32'd1);
        check("shi_11", {28'd0, shi}, 32'd1);
        check("bai_11", {28'd0, bai}, 32'd0);
        do_passes(1, 1'b0);
        rst = 1'b0;
        #1;
        check("arst_state", {30'd0, state}, 32'd0);
        check("arst_start_fail", {30'd0, start, fail}, 32'd0);
        check("arst_score", {20'd0, bai, shi, ge}, 32'd0);
        check("arst_best", {20'd0, best}, 32'd0);
        m_score = 0; m_best = 0;
        cyc(2);
        rst = 1'b1;
        cyc(2);

        // Flap and restart together in IDLE still start a game.
        dn = 1'b0; btn = 1'b1; cyc(20);
        dn = 1'b1; btn = 1'b0; cyc(20);
        check("flap_restart_play", {30'd0, state}, 32'd1);
        do_passes(1002, 1'b0);
        press_restart();
        check("restart_in_play", {30'd0, state}, 32'd1);
        check_score("sat_score");
        end_game();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
